exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl_pkg.sv | 76 +++++++
 rtl/exc_csr_file.sv | 84 ++++++++
 rtl/exc_ctrl.sv | 98 +++++++++
 tb/tb_exc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception controller: CSR numbers, field positions,
// writable-bit masks, FSM state encoding and exception codes.
package exc_ctrl_pkg;

    localparam int N_CSR      = 5;
    localparam int IDX_CRMD   = 0;
    localparam int IDX_PRMD   = 1;
    localparam int IDX_ESTAT  = 2;
    localparam int IDX_ERA    = 3;
    localparam int IDX_EENTRY = 4;

    localparam logic [13:0] CSR_CRMD   = 14'h0;
    localparam logic [13:0] CSR_PRMD   = 14'h1;
    localparam logic [13:0] CSR_ESTAT  = 14'h5;
    localparam logic [13:0] CSR_ERA    = 14'h6;
    localparam logic [13:0] CSR_EENTRY = 14'hC;

    localparam int CRMD_PLV_LO    = 0;
    localparam int CRMD_PLV_HI    = 1;
    localparam int CRMD_IE        = 2;
    localparam int CRMD_DA        = 3;
    localparam int PRMD_PPLV_LO   = 0;
    localparam int PRMD_PPLV_HI   = 1;
    localparam int PRMD_PIE       = 2;
    localparam int ESTAT_ECODE_LO = 16;
    localparam int ESTAT_ECODE_HI = 21;
    localparam int ESTAT_ESUB_LO  = 22;
    localparam int ESTAT_ESUB_HI  = 30;
    localparam int EENTRY_VA_LO   = 6;

    localparam logic [31:0] CRMD_RST = 32'h0000_0008;

    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } ctrl_state_t;

    function automatic logic [13:0] csr_num_of(input int idx);
        case (idx)
            IDX_CRMD:   return CSR_CRMD;
            IDX_PRMD:   return CSR_PRMD;
            IDX_ESTAT:  return CSR_ESTAT;
            IDX_ERA:    return CSR_ERA;
            default:    return CSR_EENTRY;
        endcase
    endfunction

    // Bits software may change; everything else is hard-wired to zero.
    function automatic logic [31:0] csr_wr_bits(input int idx);
        case (idx)
            IDX_CRMD:   return 32'h0000_000F;
            IDX_PRMD:   return 32'h0000_0007;
            IDX_ESTAT:  return 32'h7FFF_0000;
            IDX_ERA:    return 32'hFFFF_FFFF;
            default:    return 32'hFFFF_FFC0;
        endcase
    endfunction

    function automatic logic [31:0] masked_write(
        input logic [31:0] old_val,
        input logic [31:0] wvalue,
        input logic [31:0] wmask,
        input logic [31:0] writable
    );
        logic [31:0] m;
        m = wmask & writable;
        return (old_val & ~m) | (wvalue & m);
    endfunction

endpackage

// File: rtl/exc_csr_file.sv
// Exception-related CSR storage and read mux; commit events override
// any same-cycle software write on the fields they touch.
module exc_csr_file
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EENTRY_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] csr_num,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        ex_commit,
    input  logic [31:0] ex_pc,
    input  logic [5:0]  ecode,
    input  logic [8:0]  esubcode,
    input  logic        ertn_commit,
    output logic [31:0] csr_rvalue,
    output logic [31:0] eentry,
    output logic [31:0] era
);

    logic [31:0]      csr_reg    [N_CSR];
    logic [31:0]      csr_next   [N_CSR];
    logic [31:0]      wr_merged  [N_CSR];
    logic [31:0]      rst_val    [N_CSR];
    logic [N_CSR-1:0] csr_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_CSR; gi++) begin : g_csr
            assign csr_hit[gi]   = (csr_num == csr_num_of(gi));
            assign wr_merged[gi] = (csr_we && csr_hit[gi])
                                 ? masked_write(csr_reg[gi], csr_wvalue, csr_wmask, csr_wr_bits(gi))
                                 : csr_reg[gi];
            assign rst_val[gi]   = (gi == IDX_CRMD)   ? CRMD_RST :
                                   (gi == IDX_EENTRY) ? (EENTRY_RST & csr_wr_bits(IDX_EENTRY)) :
                                                        32'h0;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < N_CSR; i++) begin
            csr_next[i] = wr_merged[i];
        end
        // Event values take precedence, but are sourced from pre-write state.
        if (ex_commit) begin
            csr_next[IDX_PRMD][PRMD_PPLV_HI:PRMD_PPLV_LO]     = csr_reg[IDX_CRMD][CRMD_PLV_HI:CRMD_PLV_LO];
            csr_next[IDX_PRMD][PRMD_PIE]                      = csr_reg[IDX_CRMD][CRMD_IE];
            csr_next[IDX_CRMD][CRMD_PLV_HI:CRMD_PLV_LO]       = 2'b00;
            csr_next[IDX_CRMD][CRMD_IE]                       = 1'b0;
            csr_next[IDX_ERA]                                 = ex_pc;
            csr_next[IDX_ESTAT][ESTAT_ECODE_HI:ESTAT_ECODE_LO] = ecode;
            csr_next[IDX_ESTAT][ESTAT_ESUB_HI:ESTAT_ESUB_LO]   = esubcode;
        end else if (ertn_commit) begin
            csr_next[IDX_CRMD][CRMD_PLV_HI:CRMD_PLV_LO] = csr_reg[IDX_PRMD][PRMD_PPLV_HI:PRMD_PPLV_LO];
            csr_next[IDX_CRMD][CRMD_IE]                 = csr_reg[IDX_PRMD][PRMD_PIE];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CSR; i++) begin
            if (!resetn) begin
                csr_reg[i] <= rst_val[i];
            end else begin
                csr_reg[i] <= csr_next[i];
            end
        end
    end

    always_comb begin
        csr_rvalue = 32'h0;
        for (int i = 0; i < N_CSR; i++) begin
            if (csr_hit[i]) begin
                csr_rvalue = csr_reg[i];
            end
        end
    end

    assign eentry = csr_reg[IDX_EENTRY];
    assign era    = csr_reg[IDX_ERA];

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERTN commit controller: sequences a one-cycle flush to the
// captured redirect target, then holds the front end until the pipe drains.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EENTRY_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_ex_valid,
    input  logic [31:0] wb_ex_pc,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic        wb_is_ertn,
    input  logic        pipe_idle,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        ctrl_busy
);

    ctrl_state_t state_reg;
    logic        flush_reg;
    logic        busy_reg;
    logic [31:0] target_reg;
    logic [31:0] eentry;
    logic [31:0] era;
    logic        ex_take;
    logic        ertn_take;

    // Commit events are only honoured in IDLE; the exception wins over ERTN.
    assign ex_take   = (state_reg == ST_IDLE) && wb_ex_valid;
    assign ertn_take = (state_reg == ST_IDLE) && wb_is_ertn && !wb_ex_valid;

    exc_csr_file #(
        .EENTRY_RST (EENTRY_RST)
    ) u_csr (
        .clk         (clk),
        .resetn      (resetn),
        .csr_num     (csr_num),
        .csr_we      (csr_we),
        .csr_wmask   (csr_wmask),
        .csr_wvalue  (csr_wvalue),
        .ex_commit   (ex_take),
        .ex_pc       (wb_ex_pc),
        .ecode       (wb_ecode),
        .esubcode    (wb_esubcode),
        .ertn_commit (ertn_take),
        .csr_rvalue  (csr_rvalue),
        .eentry      (eentry),
        .era         (era)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            flush_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            target_reg <= 32'h0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ex_take || ertn_take) begin
                        state_reg  <= ST_FLUSH;
                        flush_reg  <= 1'b1;
                        busy_reg   <= 1'b1;
                        // Captured from pre-edge CSR state, immune to later writes.
                        target_reg <= ex_take ? eentry : era;
                    end
                end
                ST_FLUSH: begin
                    state_reg <= ST_DRAIN;
                    flush_reg <= 1'b0;
                end
                ST_DRAIN: begin
                    if (pipe_idle) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    flush_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign flush     = flush_reg;
    assign flush_pc  = target_reg;
    assign ctrl_busy = busy_reg;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: directed scenarios followed by random traffic,
// checked against a field-level reference model of the CSRs and flush sequencing.
module tb_exc_ctrl;
    import exc_ctrl_pkg::*;

    localparam logic [31:0] EENTRY_INIT = 32'h1C00_0100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_ex_valid;
    logic [31:0] wb_ex_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        wb_is_ertn;
    logic        pipe_idle;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ctrl_busy;

    exc_ctrl #(.EENTRY_RST(EENTRY_INIT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wb_ex_valid (wb_ex_valid),
        .wb_ex_pc    (wb_ex_pc),
        .wb_ecode    (wb_ecode),
        .wb_esubcode (wb_esubcode),
        .wb_is_ertn  (wb_is_ertn),
        .pipe_idle   (pipe_idle),
        .csr_num     (csr_num),
        .csr_rvalue  (csr_rvalue),
        .csr_we      (csr_we),
        .csr_wmask   (csr_wmask),
        .csr_wvalue  (csr_wvalue),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .ctrl_busy   (ctrl_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: architectural fields plus "blocked" sequencing state.
    logic [1:0]  m_plv, m_pplv;
    logic        m_ie, m_da, m_pie;
    logic [5:0]  m_ecode;
    logic [8:0]  m_esub;
    logic [31:0] m_era;
    logic [25:0] m_eentry;
    bit          m_busy, m_drain;

    int          exp_cyc[$];
    logic [31:0] exp_pc[$];

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [13:0] n);
        case (n)
            14'h0:   return {28'h0, m_da, m_ie, m_plv};
            14'h1:   return {29'h0, m_pie, m_pplv};
            14'h5:   return {1'b0, m_esub, m_ecode, 16'h0};
            14'h6:   return m_era;
            14'hC:   return {m_eentry, 6'h0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_plv = 2'd0; m_ie = 1'b0; m_da = 1'b1;
        m_pplv = 2'd0; m_pie = 1'b0;
        m_ecode = '0; m_esub = '0; m_era = '0;
        m_eentry = EENTRY_INIT[31:6];
        m_busy = 1'b0; m_drain = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] cur, nv, o_ent, o_era;
        logic [1:0]  o_plv, o_pplv;
        logic        o_ie, o_pie;
        if (!resetn) begin
            model_reset();
        end else begin
            o_plv = m_plv; o_ie = m_ie; o_pplv = m_pplv; o_pie = m_pie;
            o_era = m_era; o_ent = model_read(14'hC);
            if (csr_we) begin
                cur = model_read(csr_num);
                nv  = (cur & ~csr_wmask) | (csr_wvalue & csr_wmask);
                case (csr_num)
                    14'h0: begin m_plv = nv[1:0]; m_ie = nv[2]; m_da = nv[3]; end
                    14'h1: begin m_pplv = nv[1:0]; m_pie = nv[2]; end
                    14'h5: begin m_ecode = nv[21:16]; m_esub = nv[30:22]; end
                    14'h6: m_era = nv;
                    14'hC: m_eentry = nv[31:6];
                    default: ;
                endcase
            end
            if (!m_busy) begin
                if (wb_ex_valid) begin
                    m_pplv = o_plv; m_pie = o_ie; m_plv = 2'd0; m_ie = 1'b0;
                    m_era = wb_ex_pc; m_ecode = wb_ecode; m_esub = wb_esubcode;
                    exp_cyc.push_back(cyc + 1); exp_pc.push_back(o_ent);
                    m_busy = 1'b1; m_drain = 1'b0;
                end else if (wb_is_ertn) begin
                    m_plv = o_pplv; m_ie = o_pie;
                    exp_cyc.push_back(cyc + 1); exp_pc.push_back(o_era);
                    m_busy = 1'b1; m_drain = 1'b0;
                end
            end else if (!m_drain) begin
                m_drain = 1'b1;
            end else if (pipe_idle) begin
                m_busy = 1'b0;
            end
        end
    endtask

    // One clock of stimulus: compare visible state, advance model, move to next cycle.
    task automatic run_cycle(input bit chk, input logic [31:0] want, input string nm);
        @(negedge clk);
        check32("csr_rvalue", csr_rvalue, model_read(csr_num));
        check32("ctrl_busy", {31'h0, ctrl_busy}, {31'h0, m_busy});
        if (chk) check32(nm, csr_rvalue, want);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input logic pidle);
        resetn = 1'b1; wb_ex_valid = 1'b0; wb_is_ertn = 1'b0; wb_ex_pc = '0;
        wb_ecode = '0; wb_esubcode = '0; pipe_idle = pidle;
        csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0; csr_num = '0;
    endtask

    task automatic peek(input logic [13:0] n, input logic [31:0] want, input string nm);
        csr_num = n;
        run_cycle(1'b1, want, nm);
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
        csr_num = n; csr_we = 1'b1; csr_wmask = m; csr_wvalue = v;
        run_cycle(1'b0, '0, "");
        csr_we = 1'b0;
    endtask

    // Monitor: every flush pulse must match the oldest expected redirect.
    always @(negedge clk) begin
        int          c;
        logic [31:0] p;
        if (started) begin
            if (flush === 1'b1) begin
                total++;
                if (exp_pc.size() == 0) begin
                    bad++;
                    $display("FAIL flush_unexpected cyc=%0d got_pc=%h want=no_flush", cyc, flush_pc);
                end else begin
                    c = exp_cyc.pop_front();
                    p = exp_pc.pop_front();
                    if (c != cyc || flush_pc !== p) begin
                        bad++;
                        $display("FAIL flush_pc cyc=%0d got=%h want=%h at_cyc=%0d", cyc, flush_pc, p, c);
                    end
                end
            end else if (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
                total++;
                bad++;
                $display("FAIL flush_missing cyc=%0d got=0 want_pc=%h", cyc, exp_pc[0]);
                void'(exp_cyc.pop_front());
                void'(exp_pc.pop_front());
            end
        end
    end

    initial begin
        quiet(1'b1);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        started = 1'b1;
        resetn  = 1'b1;

        peek(14'h0, 32'h0000_0008, "crmd_reset");
        peek(14'hC, EENTRY_INIT, "eentry_reset");
        peek(14'h3, 32'h0, "unmapped_read");
        wr(14'h3, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        peek(14'h3, 32'h0, "unmapped_after_write");

        wr(14'hC, 32'hFFFF_FFFF, 32'h1C00_8000);
        wr(14'h0, 32'h0000_0007, 32'h0000_0007);
        peek(14'h0, 32'h0000_000F, "crmd_written");

        wb_ex_valid = 1'b1; wb_ex_pc = 32'h1C00_0040; wb_ecode = ECODE_SYS; pipe_idle = 1'b0;
        csr_num = 14'h0;
        run_cycle(1'b0, '0, "");
        quiet(1'b0);
        peek(14'h6, 32'h1C00_0040, "era_after_ex");
        peek(14'h1, 32'h0000_0007, "prmd_after_ex");
        peek(14'h0, 32'h0000_0008, "crmd_after_ex");
        pipe_idle = 1'b1;
        peek(14'h5, {10'h0, ECODE_SYS, 16'h0}, "estat_after_ex");
        run_cycle(1'b0, '0, "");

        wb_is_ertn = 1'b1; csr_num = 14'h0;
        run_cycle(1'b0, '0, "");
        quiet(1'b1);
        peek(14'h0, 32'h0000_000F, "crmd_after_ertn");
        run_cycle(1'b0, '0, "");

        wb_ex_valid = 1'b1; wb_is_ertn = 1'b1; wb_ex_pc = 32'h1C00_0080; wb_ecode = ECODE_BRK;
        run_cycle(1'b0, '0, "");
        quiet(1'b1);
        peek(14'h0, 32'h0000_0008, "crmd_ex_beats_ertn");
        run_cycle(1'b0, '0, "");

        wb_ex_valid = 1'b1; wb_ex_pc = 32'h1C00_00C0; wb_ecode = ECODE_INE; pipe_idle = 1'b0;
        run_cycle(1'b0, '0, "");
        for (int i = 0; i < 5; i++) begin
            wb_ex_pc = 32'h2000_0000 + 32'(i * 4);
            run_cycle(1'b0, '0, "");
        end
        quiet(1'b0);
        peek(14'h6, 32'h1C00_00C0, "era_unchanged_drain");
        pipe_idle = 1'b1;
        run_cycle(1'b0, '0, "");
        run_cycle(1'b0, '0, "");

        wb_ex_valid = 1'b1; wb_ex_pc = 32'h1C00_0100; wb_ecode = ECODE_ADEF;
        run_cycle(1'b0, '0, "");
        quiet(1'b1);
        resetn = 1'b0;
        run_cycle(1'b0, '0, "");
        resetn = 1'b1;
        peek(14'h0, 32'h0000_0008, "crmd_after_abort");
        run_cycle(1'b0, '0, "");

        for (int i = 0; i < 600; i++) begin
            resetn      = ($urandom_range(0, 99) >= 2);
            wb_ex_valid = ($urandom_range(0, 9) == 0);
            wb_is_ertn  = ($urandom_range(0, 9) == 0);
            wb_ex_pc    = $urandom;
            wb_ecode    = 6'($urandom);
            wb_esubcode = 9'($urandom);
            pipe_idle   = $urandom_range(0, 1) == 1;
            csr_we      = ($urandom_range(0, 9) < 3);
            csr_wmask   = $urandom;
            csr_wvalue  = $urandom;
            case ($urandom_range(0, 5))
                0: csr_num = 14'h0;
                1: csr_num = 14'h1;
                2: csr_num = 14'h5;
                3: csr_num = 14'h6;
                4: csr_num = 14'hC;
                default: csr_num = 14'($urandom_range(0, 16383));
            endcase
            run_cycle(1'b0, '0, "");
        end

        quiet(1'b1);
        repeat (4) run_cycle(1'b0, '0, "");
        check32("pending_flushes", 32'(exp_pc.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
